pkt_decap_ctrl: RTL and testbench

- Receive-side counterpart of the router controller's encapsulation path.
- Pops packets from the output-port-0 FIFO and parses the 9-bit header {TTL[8:7], pkt_number[6:2], src_router[1:0]} plus the destination address.
- Obtains an arbiter write grant, then streams payload words to local memory.
- Tracks in-order packet numbers 0..NUMBER_PACKET-1 per frame and reports frame done or error to the router controller.

---
 rtl/router_pkg.sv | 31 +++
 rtl/pkt_decap_ctrl_if.sv | 30 +++
 rtl/decap_hdr_parse.sv | 28 ++
 rtl/pkt_decap_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pkt_decap_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Router header layout, error codes and decap state encoding.
// Shared with the encapsulation path so both sides agree on field offsets.
package router_pkg;

   localparam int TTL_MSB      = 8;
   localparam int TTL_LSB      = 7;
   localparam int PKTNUM_MSB   = 6;
   localparam int PKTNUM_LSB   = 2;
   localparam int SRC_MSB      = 1;
   localparam int SRC_LSB      = 0;
   localparam int DST_ADDR_LSB = 9;

   localparam int HDR_W    = TTL_MSB + 1;
   localparam int TTL_W    = TTL_MSB - TTL_LSB + 1;
   localparam int PKTNUM_W = PKTNUM_MSB - PKTNUM_LSB + 1;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_SEQ  = 2'b01;
   localparam logic [1:0] ERR_TTL  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_POP,
      S_HDR_CHK,
      S_ARB_REQ,
      S_PAYLOAD,
      S_PKT_END,
      S_DRAIN
   } decap_state_t;

endpackage

// File: rtl/pkt_decap_ctrl_if.sv
// FIFO read, arbiter and memory write signals of the decap controller.
// master = controller side, slave = FIFO/arbiter/memory side.
interface pkt_decap_ctrl_if #(
   parameter int AURORA_DATA_WIDTH = 64,
   parameter int ADDR_WIDTH        = 10
);

   logic                         fifo_empty;
   logic                         fifo_rd_en;
   logic [AURORA_DATA_WIDTH-1:0] fifo_rd_data;
   logic                         arbiter_write_req;
   logic                         arbiter_write_gnt;
   logic [ADDR_WIDTH-1:0]        arbiter_dst_addr;
   logic                         mem_we;
   logic [ADDR_WIDTH-1:0]        mem_addr;
   logic [AURORA_DATA_WIDTH-1:0] mem_wdata;

   modport master (
      input  fifo_empty, fifo_rd_data, arbiter_write_gnt,
      output fifo_rd_en, arbiter_write_req, arbiter_dst_addr,
      output mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output fifo_empty, fifo_rd_data, arbiter_write_gnt,
      input  fifo_rd_en, arbiter_write_req, arbiter_dst_addr,
      input  mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/decap_hdr_parse.sv
// Header word field extraction plus TTL-zero and sequence checks.
module decap_hdr_parse
   import router_pkg::*;
#(
   parameter int ADDR_WIDTH             = 10,
   parameter int RECOGNIZE_ROUTER_WIDTH = 2
) (
   input  logic [DST_ADDR_LSB+ADDR_WIDTH-1:0] hdr_word,
   input  logic [PKTNUM_W-1:0]                expected,
   output logic [HDR_W-1:0]                   header,
   output logic [ADDR_WIDTH-1:0]              dst_addr,
   output logic                               ttl_zero,
   output logic                               seq_err
);

   logic [TTL_W-1:0]                  ttl;
   logic [PKTNUM_W-1:0]               num;
   logic [RECOGNIZE_ROUTER_WIDTH-1:0] src;

   assign ttl      = hdr_word[TTL_MSB:TTL_LSB];
   assign num      = hdr_word[PKTNUM_MSB:PKTNUM_LSB];
   assign src      = RECOGNIZE_ROUTER_WIDTH'(hdr_word[SRC_MSB:SRC_LSB]);
   assign header   = HDR_W'({ttl, num, src});
   assign dst_addr = hdr_word[DST_ADDR_LSB +: ADDR_WIDTH];
   assign ttl_zero = (ttl == '0);
   assign seq_err  = (num != expected);

endmodule

// File: rtl/pkt_decap_ctrl.sv
// Receive-side decap controller: FIFO -> header check -> arbiter -> memory.
// Optional DECAP_STATS_EN adds saturating good/dropped packet counters.
module pkt_decap_ctrl
   import router_pkg::*;
#(
   parameter int AURORA_DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH             = 10,
   parameter int NUMBER_PACKET          = 19,
   parameter int PAYLOAD_WORDS          = 4,
   parameter int RECOGNIZE_ROUTER_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_decap_pkt,
   pkt_decap_ctrl_if.master      bus,
   output logic [HDR_W-1:0]      header_pkt_recv,
   output logic [ADDR_WIDTH-1:0] dst_addr_recv,
   output logic                  decap_done,
   output logic                  decap_err,
   output logic [1:0]            err_code
`ifdef DECAP_STATS_EN
   ,
   output logic [15:0]           stat_pkt_ok,
   output logic [15:0]           stat_pkt_drop
`endif
);

   localparam int CNT_W = $clog2(PAYLOAD_WORDS + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(PAYLOAD_WORDS);
   localparam logic [PKTNUM_W-1:0] NUM_LAST = PKTNUM_W'(NUMBER_PACKET - 1);

   decap_state_t                 state;
   logic [PKTNUM_W-1:0]          exp_num;
   logic [CNT_W-1:0]             pop_cnt;
   logic                         pop;
   logic [AURORA_DATA_WIDTH-1:0] rd_word;
   logic [HDR_W-1:0]             hdr;
   logic [ADDR_WIDTH-1:0]        dst;
   logic                         ttl_zero;
   logic                         seq_err;

   assign rd_word = bus.fifo_rd_data;

   decap_hdr_parse #(
      .ADDR_WIDTH             (ADDR_WIDTH),
      .RECOGNIZE_ROUTER_WIDTH (RECOGNIZE_ROUTER_WIDTH)
   ) u_parse (
      .hdr_word (rd_word[DST_ADDR_LSB+ADDR_WIDTH-1:0]),
      .expected (exp_num),
      .header   (hdr),
      .dst_addr (dst),
      .ttl_zero (ttl_zero),
      .seq_err  (seq_err)
   );

   // Pop is gated by fifo_empty in the same cycle, and by the pop count
   // so a packet never pulls words belonging to the next one.
   always_comb begin
      pop = 1'b0;
      unique case (state)
         S_HDR_POP:         pop = !bus.fifo_empty;
         S_PAYLOAD, S_DRAIN: pop = !bus.fifo_empty && (pop_cnt != CNT_LAST);
         default:           pop = 1'b0;
      endcase
   end

   assign bus.fifo_rd_en = pop;
   assign bus.mem_wdata  = bus.mem_we ? rd_word : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                 <= S_IDLE;
         exp_num               <= '0;
         pop_cnt               <= '0;
         bus.arbiter_write_req <= 1'b0;
         bus.arbiter_dst_addr  <= '0;
         bus.mem_we            <= 1'b0;
         bus.mem_addr          <= '0;
         header_pkt_recv       <= '0;
         dst_addr_recv         <= '0;
         decap_done            <= 1'b0;
         decap_err             <= 1'b0;
         err_code              <= ERR_NONE;
`ifdef DECAP_STATS_EN
         stat_pkt_ok           <= '0;
         stat_pkt_drop         <= '0;
`endif
      end else begin
         decap_done <= 1'b0;
         decap_err  <= 1'b0;
         bus.mem_we <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (start_decap_pkt) begin
                  err_code <= ERR_NONE;
                  exp_num  <= '0;
                  state    <= S_HDR_POP;
               end
            end
            S_HDR_POP: begin
               if (pop) state <= S_HDR_CHK;
            end
            S_HDR_CHK: begin
               header_pkt_recv <= hdr;
               dst_addr_recv   <= dst;
               pop_cnt         <= '0;
               if (ttl_zero) begin
                  err_code <= ERR_TTL;
                  state    <= S_DRAIN;
               end else if (seq_err) begin
                  err_code <= ERR_SEQ;
                  state    <= S_DRAIN;
               end else begin
                  bus.arbiter_write_req <= 1'b1;
                  bus.arbiter_dst_addr  <= dst;
                  state                 <= S_ARB_REQ;
               end
            end
            S_ARB_REQ: begin
               if (bus.arbiter_write_gnt) state <= S_PAYLOAD;
            end
            S_PAYLOAD: begin
               bus.mem_we   <= pop;
               bus.mem_addr <= bus.arbiter_dst_addr + ADDR_WIDTH'(pop_cnt);
               if (pop) pop_cnt <= pop_cnt + 1'b1;
               // Full count here means the last write is on the bus now
               if (pop_cnt == CNT_LAST) begin
                  bus.arbiter_write_req <= 1'b0;
                  state                 <= S_PKT_END;
               end
            end
            S_PKT_END: begin
`ifdef DECAP_STATS_EN
               if (stat_pkt_ok != 16'hFFFF) stat_pkt_ok <= stat_pkt_ok + 16'd1;
`endif
               if (exp_num == NUM_LAST) begin
                  decap_done <= 1'b1;
                  exp_num    <= '0;
                  state      <= S_IDLE;
               end else begin
                  exp_num <= exp_num + 1'b1;
                  state   <= S_HDR_POP;
               end
            end
            S_DRAIN: begin
               if (pop) pop_cnt <= pop_cnt + 1'b1;
               if (pop_cnt == CNT_LAST) begin
`ifdef DECAP_STATS_EN
                  if (stat_pkt_drop != 16'hFFFF)
                     stat_pkt_drop <= stat_pkt_drop + 16'd1;
`endif
                  decap_err <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pkt_decap_ctrl.sv
// Directed bench for pkt_decap_ctrl: FIFO/arbiter models and write scoreboard.
module tb_pkt_decap_ctrl;

   localparam int DW  = 64;
   localparam int AW  = 10;
   localparam int NP  = 19;
   localparam int PW  = 4;
   localparam int BUDGET = 4000;

   typedef struct {
      int         k;
      logic [1:0] good_ttl;
      logic [1:0] bad_ttl;
      logic [4:0] bad_num;
      logic [9:0] base;
      bit         bubble;
      int         gdel;
      logic [1:0] exp_code;
      int         exp_done;
      int         exp_err;
      int         exp_wr;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [8:0]    header_pkt_recv;
   logic [AW-1:0] dst_addr_recv;
   logic          decap_done;
   logic          decap_err;
   logic [1:0]    err_code;
`ifdef DECAP_STATS_EN
   logic [15:0]   stat_ok;
   logic [15:0]   stat_drop;
`endif

   pkt_decap_ctrl_if #(.AURORA_DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   pkt_decap_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_decap_pkt (start),
      .bus             (bus.master),
      .header_pkt_recv (header_pkt_recv),
      .dst_addr_recv   (dst_addr_recv),
      .decap_done      (decap_done),
      .decap_err       (decap_err),
      .err_code        (err_code)
`ifdef DECAP_STATS_EN
      ,
      .stat_pkt_ok     (stat_ok),
      .stat_pkt_drop   (stat_drop)
`endif
   );

   always #5 clk = ~clk;

   logic [DW-1:0] fifo_mem [0:255];
   int            rd_ptr = 0;
   int            wr_ptr = 0;
   bit            bubble = 1'b0;
   bit            bubble_en = 1'b0;
   int            gnt_delay = 0;
   int            req_cycles = 0;
   logic [AW-1:0] exp_addr [$];
   logic [DW-1:0] exp_data [$];
   int            nwr = 0;
   int            n_done = 0;
   int            n_err = 0;
   int            total = 0;
   int            bad = 0;
   vec_t          vecs [7];

   assign bus.fifo_empty = (rd_ptr >= wr_ptr) || bubble;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk_hdr(input logic [1:0] ttl,
                                            input logic [4:0] num,
                                            input logic [9:0] dst);
      logic [DW-1:0] w;
      w = {$urandom, $urandom};
      w[18:0] = {dst, ttl, num, 2'd1};
      return w;
   endfunction

   // Called at a negedge: observe, advance one clock, update models.
   task automatic step();
      logic popped;
      popped = bus.fifo_rd_en;
      if (popped) chk("pop_not_empty", bus.fifo_empty, 1'b0);
      if (bus.arbiter_write_req && !bus.arbiter_write_gnt) begin
         chk("arb_wait_nopop", popped, 1'b0);
         if (exp_addr.size() > 0)
            chk("arb_dst_hold", bus.arbiter_dst_addr, exp_addr[0]);
      end
      if (bus.mem_we) begin
         chk("sb_pending", exp_addr.size() > 0, 1'b1);
         if (exp_addr.size() > 0) begin
            chk("wr_addr", bus.mem_addr, exp_addr.pop_front());
            chk("wr_data", bus.mem_wdata, exp_data.pop_front());
         end
         nwr++;
      end
      if (decap_done) n_done++;
      if (decap_err) n_err++;
      if (decap_done || decap_err)
         chk("done_err_excl", decap_done && decap_err, 1'b0);
      @(posedge clk);
      #1;
      if (popped) begin
         if (rd_ptr < wr_ptr) bus.fifo_rd_data = fifo_mem[rd_ptr];
         rd_ptr++;
      end
      bubble = bubble_en ? ~bubble : 1'b0;
      if (bus.arbiter_write_req) req_cycles++;
      else req_cycles = 0;
      bus.arbiter_write_gnt = bus.arbiter_write_req && (req_cycles > gnt_delay);
      @(negedge clk);
   endtask

   task automatic load_good(input int n, input logic [1:0] ttl,
                            input logic [9:0] dst);
      logic [DW-1:0] d;
      fifo_mem[wr_ptr] = mk_hdr(ttl, n[4:0], dst);
      wr_ptr++;
      for (int w = 0; w < PW; w++) begin
         d = {$urandom, $urandom};
         fifo_mem[wr_ptr] = d;
         wr_ptr++;
         exp_addr.push_back(dst + AW'(w));
         exp_data.push_back(d);
      end
   endtask

   task automatic run_vec(input int id, input vec_t v);
      int cyc;
      rd_ptr = 0; wr_ptr = 0; nwr = 0; n_done = 0; n_err = 0;
      exp_addr.delete(); exp_data.delete();
      bubble_en = v.bubble; gnt_delay = v.gdel;
      for (int n = 0; n < v.k; n++)
         load_good(n, v.good_ttl, v.base + AW'(4 * n));
      if (v.k < NP) begin
         fifo_mem[wr_ptr] = mk_hdr(v.bad_ttl, v.bad_num, v.base + AW'(4 * v.k));
         wr_ptr++;
         for (int w = 0; w < PW; w++) begin
            fifo_mem[wr_ptr] = {$urandom, $urandom};
            wr_ptr++;
         end
      end
      start = 1'b1;
      step();
      start = 1'b0;
      chk($sformatf("v%0d_code_clear", id), err_code, 2'b00);
      cyc = 0;
      while (n_done + n_err == 0 && cyc < BUDGET) begin
         step();
         cyc++;
      end
      chk($sformatf("v%0d_no_timeout", id), cyc < BUDGET, 1'b1);
      repeat (3) step();
      bubble_en = 1'b0;
      chk($sformatf("v%0d_err_code", id), err_code, v.exp_code);
      chk($sformatf("v%0d_done_cnt", id), n_done, v.exp_done);
      chk($sformatf("v%0d_err_cnt", id), n_err, v.exp_err);
      chk($sformatf("v%0d_writes", id), nwr, v.exp_wr);
      chk($sformatf("v%0d_pops", id), rd_ptr, wr_ptr);
      chk($sformatf("v%0d_sb_left", id), exp_addr.size(), 0);
      chk($sformatf("v%0d_req_idle", id), bus.arbiter_write_req, 1'b0);
   endtask

   initial begin
      int   cyc;
      int   saved;
      bus.fifo_rd_data      = '0;
      bus.arbiter_write_gnt = 1'b0;

      //        k  gt    bt    bn    base      bub gd code  d  e  wr
      vecs[0] = '{19, 2'd3, 2'd0, 5'd0, 10'h100, 0, 0,  2'b00, 1, 0, 76};
      vecs[1] = '{2,  2'd3, 2'd3, 5'd3, 10'h100, 0, 0,  2'b01, 0, 1, 8};
      vecs[2] = '{0,  2'd3, 2'd0, 5'd0, 10'h100, 0, 0,  2'b10, 0, 1, 0};
      vecs[3] = '{5,  2'd3, 2'd0, 5'd9, 10'h080, 0, 1,  2'b10, 0, 1, 20};
      vecs[4] = '{19, 2'd3, 2'd0, 5'd0, 10'h200, 1, 0,  2'b00, 1, 0, 76};
      vecs[5] = '{19, 2'd1, 2'd0, 5'd0, 10'h3F0, 0, 10, 2'b00, 1, 0, 76};
      vecs[6] = '{18, 2'd2, 2'd2, 5'd0, 10'h010, 1, 2,  2'b01, 0, 1, 72};

      repeat (2) @(negedge clk);
      chk("rst_rd_en", bus.fifo_rd_en, 1'b0);
      chk("rst_req", bus.arbiter_write_req, 1'b0);
      chk("rst_we", bus.mem_we, 1'b0);
      chk("rst_addr", bus.mem_addr, 0);
      chk("rst_hdr", header_pkt_recv, 0);
      chk("rst_done_err", {decap_done, decap_err, err_code}, 0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);
      chk("last_hdr_seq", header_pkt_recv, {2'd2, 5'd0, 2'd1});

      // Wrap 3FE..001, then reset in the middle of the next payload
      rd_ptr = 0; wr_ptr = 0; nwr = 0; n_done = 0; n_err = 0;
      exp_addr.delete(); exp_data.delete();
      gnt_delay = 0;
      load_good(0, 2'd3, 10'h3FE);
      load_good(1, 2'd3, 10'h002);
      start = 1'b1;
      step();
      start = 1'b0;
      cyc = 0;
      while (nwr < 6 && cyc < 200) begin
         start = (cyc == 5);
         step();
         cyc++;
      end
      start = 1'b0;
      chk("wrap_no_timeout", cyc < 200, 1'b1);
      chk("wrap_dst_recv", dst_addr_recv, 10'h002);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_rd_en", bus.fifo_rd_en, 1'b0);
      chk("mid_rst_req", bus.arbiter_write_req, 1'b0);
      chk("mid_rst_arb_dst", bus.arbiter_dst_addr, 0);
      chk("mid_rst_we", bus.mem_we, 1'b0);
      chk("mid_rst_addr", bus.mem_addr, 0);
      chk("mid_rst_wdata", bus.mem_wdata, 0);
      chk("mid_rst_hdr", header_pkt_recv, 0);
      chk("mid_rst_dst", dst_addr_recv, 0);
      chk("mid_rst_pulses", {decap_done, decap_err}, 0);
      chk("mid_rst_code", err_code, 0);
      @(negedge clk);
      repeat (3) step();
      rst_n = 1'b1;
      saved = rd_ptr;
      repeat (4) step();
      chk("post_rst_no_pop", rd_ptr, saved);
      chk("post_rst_no_done", n_done, 0);
      chk("post_rst_no_err", n_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
